fpu_addsub_ctrl: RTL and testbench

FPU_ADDSUB_CTRL -- requirements
Module: fpu_addsub_ctrl

---
 rtl/fpu_addsub_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_fpu_addsub_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_ctrl.sv
// fpu_addsub_ctrl
//   Control FSM for a single-precision add/subtract unit. It accepts one
//   request at a time, latches the operands, and registers their
//   classification. The operation then completes in one of three ways:
//   - it takes the combinational fast-path result, or
//   - it starts the slow datapath and waits for slow_done_i, or
//   - it gives up after SLOW_TIMEOUT EXEC cycles with a quiet NaN and NV.
//   The response is held until out_ready_i accepts it.
//
// Ports
//   clk_i, reset_i               clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      request handshake (ready only in IDLE)
//   a_i, b_i, sub_op_i, rm_i     request operands, 1 = A-B, rounding mode
//   op_a_o, op_b_o, sub_op_o, rm_o  latched request to the datapaths
//   is_zero/inf/nan_a/b_o        registered operand classification
//   is_signaling_o               any signaling NaN operand
//   mux_fastres_sel_i, fast_res_i, overflow_fast_i, invalid_fast_i
//                                fast-path result, sampled in CLASSIFY
//   slow_start_o                 start pulse to the slow datapath
//   slow_done_i, slow_res_i, slow_flags_i   slow datapath completion
//   flush_i                      synchronous abort of the current operation
//   out_valid_o / out_ready_i    response handshake
//   result_o, fflags_o           response data, flags {NV,DZ,OF,UF,NX}
//   timeout_o                    one-cycle pulse after a slow-path timeout
module fpu_addsub_ctrl #(
  parameter int unsigned SLOW_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_op_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        sub_op_o,
  output logic [2:0]  rm_o,
  output logic        is_zero_a_o,
  output logic        is_zero_b_o,
  output logic        is_inf_a_o,
  output logic        is_inf_b_o,
  output logic        is_nan_a_o,
  output logic        is_nan_b_o,
  output logic        is_signaling_o,
  input  logic        mux_fastres_sel_i,
  input  logic [31:0] fast_res_i,
  input  logic        overflow_fast_i,
  input  logic        invalid_fast_i,
  output logic        slow_start_o,
  input  logic        slow_done_i,
  input  logic [31:0] slow_res_i,
  input  logic [4:0]  slow_flags_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = (SLOW_TIMEOUT > 1) ? $clog2(SLOW_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOW_TIMEOUT - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [4:0]  NV_FLAG = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_EXEC     = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic             sub_q, sub_d;
  logic [2:0]       rm_q, rm_d;
  // {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, signaling}
  logic [6:0]       cls_q, cls_d;
  logic [31:0]      result_q, result_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             timeout_q, timeout_d;
  logic             slow_start_s;

  function automatic logic f_is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic f_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // A NaN is signaling when its quiet bit (mantissa MSB) is clear.
  function automatic logic f_is_snan(input logic [31:0] x);
    return f_is_nan(x) && !x[22];
  endfunction

  // Next-state and datapath-capture logic for the control FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    sub_d        = sub_q;
    rm_d         = rm_q;
    cls_d        = cls_q;
    result_d     = result_q;
    fflags_d     = fflags_q;
    timeout_d    = 1'b0;
    slow_start_s = 1'b0;
    if (flush_i) begin
      // Abort wins over every other transition, including a pending done.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            op_a_d  = a_i;
            op_b_d  = b_i;
            sub_d   = sub_op_i;
            rm_d    = rm_i;
            cls_d   = {f_is_zero(a_i), f_is_zero(b_i), f_is_inf(a_i), f_is_inf(b_i),
                       f_is_nan(a_i), f_is_nan(b_i), f_is_snan(a_i) || f_is_snan(b_i)};
            state_d = S_CLASSIFY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLASSIFY: begin
          if (mux_fastres_sel_i) begin
            result_d = fast_res_i;
            fflags_d = {invalid_fast_i, 1'b0, overflow_fast_i, 1'b0, overflow_fast_i};
            state_d  = S_RESP;
          end else begin
            slow_start_s = 1'b1;
            cnt_d        = '0;
            state_d      = S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (slow_done_i) begin
            result_d = slow_res_i;
            fflags_d = slow_flags_i;
            state_d  = S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            result_d  = QNAN;
            fflags_d  = NV_FLAG;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_RESP: begin
          if (out_ready_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, latched request, classification and response registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      sub_q     <= 1'b0;
      rm_q      <= 3'b000;
      cls_q     <= 7'b0;
      result_q  <= 32'h0;
      fflags_q  <= 5'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sub_q     <= sub_d;
      rm_q      <= rm_d;
      cls_q     <= cls_d;
      result_q  <= result_d;
      fflags_q  <= fflags_d;
      timeout_q <= timeout_d;
    end
  end

  // Ready is withheld during a flush so a request is never silently dropped.
  assign in_ready_o   = (state_q == S_IDLE) && !flush_i;
  assign out_valid_o  = (state_q == S_RESP);
  assign slow_start_o = slow_start_s;
  assign timeout_o    = timeout_q;
  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign sub_op_o     = sub_q;
  assign rm_o         = rm_q;
  assign result_o     = result_q;
  assign fflags_o     = fflags_q;
  assign {is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o,
          is_nan_a_o, is_nan_b_o, is_signaling_o} = cls_q;

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
module tb_fpu_addsub_ctrl;

  localparam int T_OUT = 16;

  logic        clk_i, reset_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] a_i, b_i;
  logic        sub_op_i;
  logic [2:0]  rm_i;
  logic [31:0] op_a_o, op_b_o;
  logic        sub_op_o;
  logic [2:0]  rm_o;
  logic        is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o;
  logic        is_nan_a_o, is_nan_b_o, is_signaling_o;
  logic        mux_fastres_sel_i;
  logic [31:0] fast_res_i;
  logic        overflow_fast_i, invalid_fast_i;
  logic        slow_start_o, slow_done_i;
  logic [31:0] slow_res_i;
  logic [4:0]  slow_flags_i;
  logic        flush_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic        timeout_o;

  fpu_addsub_ctrl #(.SLOW_TIMEOUT(T_OUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .sub_op_i(sub_op_i), .rm_i(rm_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .sub_op_o(sub_op_o), .rm_o(rm_o),
    .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
    .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
    .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
    .is_signaling_o(is_signaling_o),
    .mux_fastres_sel_i(mux_fastres_sel_i), .fast_res_i(fast_res_i),
    .overflow_fast_i(overflow_fast_i), .invalid_fast_i(invalid_fast_i),
    .slow_start_o(slow_start_o), .slow_done_i(slow_done_i),
    .slow_res_i(slow_res_i), .slow_flags_i(slow_flags_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .fflags_o(fflags_o), .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [2:0]  rm;
    logic [6:0]  cls;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   start_cnt = 0;
  int   tmo_cnt = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference classification from the IEEE-754 value ranges of |x|.
  function automatic logic [6:0] cls_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    logic na, nb;
    ma = a & 32'h7FFF_FFFF;
    mb = b & 32'h7FFF_FFFF;
    na = ma > 32'h7F80_0000;
    nb = mb > 32'h7F80_0000;
    return {ma == 32'h0, mb == 32'h0, ma == 32'h7F80_0000, mb == 32'h7F80_0000, na, nb,
            (na && ma < 32'h7FC0_0000) || (nb && mb < 32'h7FC0_0000)};
  endfunction

  function automatic logic [6:0] cls_dut();
    return {is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o,
            is_nan_a_o, is_nan_b_o, is_signaling_o};
  endfunction

  // Event counters for start and timeout pulses.
  always @(negedge clk_i) begin
    if (!reset_i && slow_start_o) start_cnt++;
    if (!reset_i && timeout_o) tmo_cnt++;
  end

  // Monitor: pops the scoreboard on every accepted response.
  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_response", 128'(result_o), 128'h1_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 128'(result_o), 128'(e.res));
        check("fflags", 128'(fflags_o), 128'(e.flags));
        check("held_operands", 128'({op_a_o, op_b_o, sub_op_o, rm_o}),
              128'({e.a, e.b, e.sub, e.rm}));
        check("held_class", 128'(cls_dut()), 128'(e.cls));
      end
    end
  end

  // Caller is just after a rising edge; returns at the CLASSIFY falling edge.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [2:0] rm);
    logic rdy;
    rdy = 1'b0;
    a_i = a; b_i = b; sub_op_i = sub; rm_i = rm; in_valid_i = 1'b1;
    for (int t = 0; t < 50 && !rdy; t++) begin
      @(negedge clk_i);
      rdy = in_ready_o;
      @(posedge clk_i);
    end
    #1;
    in_valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom;
    check("accept", 128'(rdy), 128'(1'b1));
    @(negedge clk_i);
    check("class", 128'(cls_dut()), 128'(cls_model(a, b)));
    check("latched_ops", 128'({op_a_o, op_b_o, sub_op_o, rm_o}), 128'({a, b, sub, rm}));
  endtask

  // mode: 0 fast path, 1 slow path (done after 'delay' EXEC cycles), 2 timeout.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [2:0] rm, input int mode, input logic [31:0] res,
                       input logic [4:0] flg, input logic inv, input logic ovf,
                       input int delay, input int hold, input logic noise);
    exp_t e;
    int s0, t0;
    s0 = start_cnt;
    t0 = tmo_cnt;
    mux_fastres_sel_i = (mode == 0);
    fast_res_i = (mode == 0) ? res : $urandom;
    invalid_fast_i = inv;
    overflow_fast_i = ovf;
    slow_res_i = (mode == 1) ? res : $urandom;
    slow_flags_i = (mode == 1) ? flg : 5'($urandom);
    slow_done_i = (mode == 0) ? noise : 1'b0;
    out_ready_i = (hold > 0) ? 1'b0 : 1'b1;
    do_accept(a, b, sub, rm);
    e.a = a; e.b = b; e.sub = sub; e.rm = rm; e.cls = cls_model(a, b);
    if (mode == 0) begin
      e.res = res;
      e.flags = 5'((inv ? 16 : 0) + (ovf ? 5 : 0));
    end else if (mode == 1) begin
      e.res = res;
      e.flags = flg;
    end else begin
      e.res = 32'h7FC0_0000;
      e.flags = 5'b10000;
    end
    sb.push_back(e);
    check("slow_start", 128'(slow_start_o), 128'(mode != 0));
    if (mode == 0) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("fast_latency", 128'(out_valid_o), 128'(1'b1));
    end else if (mode == 1) begin
      @(posedge clk_i); #1;
      for (int i = 0; i < delay; i++) begin
        @(posedge clk_i); #1;
      end
      slow_done_i = 1'b1;
      @(posedge clk_i); #1;
      slow_done_i = 1'b0;
      @(negedge clk_i);
      check("slow_latency", 128'(out_valid_o), 128'(1'b1));
    end else begin
      @(posedge clk_i);
      for (int i = 0; i < T_OUT - 1; i++) @(posedge clk_i);
      @(negedge clk_i);
      check("tmo_not_early", 128'(out_valid_o), 128'(1'b0));
      @(posedge clk_i);
      @(negedge clk_i);
      check("tmo_valid", 128'(out_valid_o), 128'(1'b1));
      check("tmo_pulse", 128'(timeout_o), 128'(1'b1));
    end
    for (int i = 0; i < hold; i++) begin
      if (i > 0) @(negedge clk_i);
      check("bp_valid", 128'(out_valid_o), 128'(1'b1));
      check("bp_in_ready", 128'(in_ready_o), 128'(1'b0));
      check("bp_result", 128'({result_o, fflags_o}), 128'({e.res, e.flags}));
    end
    if (hold > 0) begin
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
    end
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk_i); #1;
    end
    check("drain", 128'(sb.size()), 128'(0));
    check("start_pulses", 128'(start_cnt - s0), 128'(mode != 0));
    check("tmo_pulses", 128'(tmo_cnt - t0), 128'(mode == 2));
    @(posedge clk_i); #1;
    slow_done_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 8))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0000;
      5: return 32'h7F80_0001;
      6: return 32'hFFA0_0000;
      7: return 32'h3F80_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_i = 1'b1;
    in_valid_i = 1'b0; a_i = 32'h0; b_i = 32'h0; sub_op_i = 1'b0; rm_i = 3'b000;
    mux_fastres_sel_i = 1'b0; fast_res_i = 32'h0; overflow_fast_i = 1'b0;
    invalid_fast_i = 1'b0; slow_done_i = 1'b0; slow_res_i = 32'h0;
    slow_flags_i = 5'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    #3;
    check("reset_state", 128'({out_valid_o, slow_start_o, timeout_o, result_o, fflags_o,
                               op_a_o, op_b_o, sub_op_o, rm_o, cls_dut()}), 128'h0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_reset", 128'(in_ready_o), 128'(1'b1));
    @(posedge clk_i); #1;

    // Directed: fast add, invalid inf-inf, slow path, done on the last cycle, timeout.
    issue(32'h0000_0000, 32'h3F80_0000, 1'b0, 3'd0, 0, 32'h3F80_0000, 5'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'd1, 0, 32'h7FC0_0000, 5'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd2, 1, 32'h4040_0000, 5'b00001, 1'b0, 1'b0, 4, 0, 1'b0);
    issue(32'h4000_0000, 32'hC000_0000, 1'b1, 3'd3, 1, 32'h1234_5678, 5'b00110, 1'b0, 1'b0, T_OUT - 1, 0, 1'b0);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'd4, 2, 32'h0, 5'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    // Backpressure on a fast response with overflow.
    issue(32'h7F00_0000, 32'h7F00_0000, 1'b0, 3'd0, 0, 32'h7F80_0000, 5'b0, 1'b0, 1'b1, 0, 5, 1'b0);

    // Flush in EXEC: no response, late done ignored.
    mux_fastres_sel_i = 1'b0;
    slow_res_i = 32'hDEAD_BEEF;
    slow_flags_i = 5'b11111;
    do_accept(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_idle", 128'({in_ready_o, out_valid_o}), 128'(2'b10));
    @(posedge clk_i); #1;
    slow_done_i = 1'b1;
    @(posedge clk_i); #1;
    slow_done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("flush_no_resp", 128'(out_valid_o), 128'(1'b0));
    end
    @(posedge clk_i); #1;

    // Signaling NaN classification, then reset mid-EXEC.
    mux_fastres_sel_i = 1'b0;
    do_accept(32'h7F80_0001, 32'h3F80_0000, 1'b1, 3'd5);
    check("snan_flags", 128'({is_nan_a_o, is_signaling_o}), 128'(2'b11));
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    #1;
    check("reset_mid_exec", 128'({out_valid_o, slow_start_o, timeout_o, result_o, fflags_o,
                                  op_a_o, op_b_o, sub_op_o, rm_o, cls_dut()}), 128'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_mid_reset", 128'({in_ready_o, out_valid_o}), 128'(2'b10));
    @(posedge clk_i); #1;

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      int r, mode, hold;
      r = $urandom_range(0, 9);
      mode = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      issue(pick_operand(), pick_operand(), 1'($urandom), 3'($urandom), mode,
            $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, T_OUT - 1), hold, 1'($urandom));
    end

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
